// File: rtl/gpio_crossbar.sv
// gpio_crossbar: N-input to M-output pin crossbar. Inputs are synchronised,
// each output selects any synchronised input with its own invert/enable, and
// remaps are break-before-make: the output is held low for GUARD cycles before
// the new source takes over.
module gpio_crossbar #(
   parameter int N_IN        = 16,
   parameter int N_OUT       = 16,
   parameter int SEL_W       = 4,
   parameter int IDX_W       = 5,
   parameter int SYNC_STAGES = 2,
   parameter int GUARD       = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_IN-1:0]    gpio_in,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [IDX_W-1:0]   cfg_idx,
   input  logic [SEL_W-1:0]   cfg_sel,
   input  logic               cfg_inv,
   input  logic               cfg_en,
   output logic               cfg_err,
   output logic [N_OUT-1:0]   out,
   output logic [N_OUT-1:0]   switching
);

   localparam int              N_SRC    = 1 << SEL_W;
   localparam logic [7:0]      LP_GUARD = 8'(GUARD);
   localparam logic [IDX_W:0]  LP_N_OUT = (IDX_W+1)'(N_OUT);
   localparam logic [SEL_W:0]  LP_N_IN  = (SEL_W+1)'(N_IN);

   logic [N_IN-1:0]   r_sync [SYNC_STAGES];
   logic [SEL_W-1:0]  r_act_sel [N_OUT];
   logic [SEL_W-1:0]  r_pend_sel [N_OUT];
   logic [7:0]        r_guard [N_OUT];
   logic [N_OUT-1:0]  r_act_inv;
   logic [N_OUT-1:0]  r_act_en;
   logic [N_OUT-1:0]  r_pend_inv;
   logic [N_OUT-1:0]  r_pend_en;
   logic [N_OUT-1:0]  r_out;
   logic              r_err;

   logic [N_SRC-1:0]  w_src;
   logic [N_OUT-1:0]  w_busy;
   logic [N_OUT-1:0]  w_hit;
   logic              w_ready;
   logic              w_accept;
   logic              w_bad;

   // Input synchroniser chain; the last stage is the usable copy of the pins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
      end else begin
         r_sync[0] <= gpio_in;
         for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
      end
   end

   // Zero-pad so selectors beyond N_IN read a defined low source.
   assign w_src = N_SRC'(r_sync[SYNC_STAGES-1]);

   // Guard activity per output and config-port handshake decode.
   always_comb begin
      w_busy  = '0;
      w_hit   = '0;
      w_ready = 1'b1;
      for (int i = 0; i < N_OUT; i++) begin
         w_busy[i] = (r_guard[i] != 8'd0);
         if ((cfg_idx == IDX_W'(i)) && (r_guard[i] != 8'd0)) w_ready = 1'b0;
      end
      w_accept = cfg_valid && w_ready;
      w_bad    = ({1'b0, cfg_idx} >= LP_N_OUT) || ({1'b0, cfg_sel} >= LP_N_IN);
      for (int i = 0; i < N_OUT; i++) begin
         w_hit[i] = w_accept && !w_bad && (cfg_idx == IDX_W'(i));
      end
   end

   // Mapping table: new entries park in pending while the guard counts down,
   // then move to active on the last guard cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_OUT; i++) begin
            r_act_sel[i]  <= '0;
            r_pend_sel[i] <= '0;
            r_guard[i]    <= '0;
         end
         r_act_inv  <= '0;
         r_act_en   <= '0;
         r_pend_inv <= '0;
         r_pend_en  <= '0;
      end else begin
         for (int i = 0; i < N_OUT; i++) begin
            if (w_hit[i]) begin
               if (GUARD == 0) begin
                  r_act_sel[i] <= cfg_sel;
                  r_act_inv[i] <= cfg_inv;
                  r_act_en[i]  <= cfg_en;
               end else begin
                  r_pend_sel[i] <= cfg_sel;
                  r_pend_inv[i] <= cfg_inv;
                  r_pend_en[i]  <= cfg_en;
                  r_guard[i]    <= LP_GUARD;
               end
            end else if (w_busy[i]) begin
               r_guard[i] <= r_guard[i] - 8'd1;
               if (r_guard[i] == 8'd1) begin
                  r_act_sel[i] <= r_pend_sel[i];
                  r_act_inv[i] <= r_pend_inv[i];
                  r_act_en[i]  <= r_pend_en[i];
               end
            end
         end
      end
   end

   // Registered output pins (forced low while guarding or disabled) and reject pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out <= '0;
         r_err <= 1'b0;
      end else begin
         for (int i = 0; i < N_OUT; i++) begin
            r_out[i] <= (w_busy[i] || !r_act_en[i]) ? 1'b0
                        : (w_src[r_act_sel[i]] ^ r_act_inv[i]);
         end
         r_err <= w_accept && w_bad;
      end
   end

   assign cfg_ready = w_ready;
   assign cfg_err   = r_err;
   assign out       = r_out;
   assign switching = w_busy;

endmodule
